// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: oversampled PS/2 keyboard receiver that emits one scan code per key event.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       break_out,
  output logic       ext_out,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t        state, state_nxt;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, flip, fall, dat, good;
  logic [FW-1:0] flt_cnt;
  logic [7:0]    shreg, shreg_nxt, code_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          brk_pend, brk_nxt, ext_pend, ext_nxt;
  logic          brk_out_nxt, ext_out_nxt, valid_nxt, err_nxt;

  assign dat  = dat_sync[1];
  // The filtered clock flips on the FILTER_LEN-th consecutive disagreeing sample
  assign flip = (clk_sync[1] != clk_filt) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall = flip && clk_filt;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      flt_cnt  <= (clk_sync[1] != clk_filt && !flip) ? flt_cnt + 1'b1 : '0;
      if (flip) clk_filt <= clk_sync[1];
    end

`ifdef PS2_PARITY_CHECK_EN
  logic par;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) par <= 1'b0;
    else if (fall && state == PARITY) par <= dat;
  assign good = dat && (^{shreg, par});
`else
  assign good = dat;
`endif

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      break_out  <= 1'b0;
      ext_out    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      tmo_cnt    <= tmo_nxt;
      brk_pend   <= brk_nxt;
      ext_pend   <= ext_nxt;
      scan_code  <= code_nxt;
      scan_valid <= valid_nxt;
      break_out  <= brk_out_nxt;
      ext_out    <= ext_out_nxt;
      frame_err  <= err_nxt;
    end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    brk_nxt     = brk_pend;
    ext_nxt     = ext_pend;
    code_nxt    = scan_code;
    brk_out_nxt = break_out;
    ext_out_nxt = ext_out;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    tmo_nxt     = (fall || state == IDLE) ? '0 : tmo_cnt + 1'b1;
    if (fall) begin
      case (state)
        IDLE: begin
          state_nxt   = dat ? IDLE : DATA;
          err_nxt     = dat;
          bit_cnt_nxt = '0;
        end
        DATA: begin
          shreg_nxt   = {dat, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          state_nxt   = (bit_cnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: state_nxt = STOP;
        default: begin
          state_nxt = IDLE;
          if (!good) begin
            err_nxt = 1'b1;
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
          end else if (shreg == 8'hF0) begin
            brk_nxt = 1'b1;
          end else if (shreg == 8'hE0) begin
            ext_nxt = 1'b1;
          end else begin
            code_nxt    = shreg;
            brk_out_nxt = brk_pend;
            ext_out_nxt = ext_pend;
            valid_nxt   = 1'b1;
            brk_nxt     = 1'b0;
            ext_nxt     = 1'b0;
          end
        end
      endcase
    end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_nxt = IDLE;
      shreg_nxt = '0;
      err_nxt   = 1'b1;
      brk_nxt   = 1'b0;
      ext_nxt   = 1'b0;
      tmo_nxt   = '0;
    end
  end
endmodule
